// File: rtl/fsk_rx_buffer.sv
// FSK receive buffer: packs demodulated nibble pairs into bytes and queues them
// in a DEPTH-entry FIFO with registered pop, sticky overflow and synchronous flush.
module fsk_rx_buffer #(
  parameter int unsigned DEPTH      = 8,
  parameter bit          HIGH_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic [3:0]               data_in,
  input  logic                     flush,
  input  logic                     clr_ovf,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     half,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    S_FIRST  = 1'b0,
    S_SECOND = 1'b1
  } nib_state_e;

  nib_state_e       state_q, state_d;
  logic [3:0]       nib_q, nib_d;
  logic             wr_prev_q;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       mem_q [DEPTH];

  logic             empty_w, full_w;
  logic             cap, push, pop, push_ok, ovf_evt;
  logic [7:0]       byte_w;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CW'(DEPTH));
  assign cap     = wr & ~wr_prev_q;
  assign byte_w  = HIGH_FIRST ? {nib_q, data_in} : {data_in, nib_q};

  always_comb begin
    state_d    = state_q;
    nib_d      = nib_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q;
    push       = 1'b0;
    pop        = 1'b0;
    push_ok    = 1'b0;
    ovf_evt    = 1'b0;

    if (flush) begin
      state_d  = S_FIRST;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (cap) begin
        unique case (state_q)
          S_FIRST: begin
            nib_d   = data_in;
            state_d = S_SECOND;
          end
          S_SECOND: begin
            state_d = S_FIRST;
            push    = 1'b1;
          end
          default: state_d = S_FIRST;
        endcase
      end

      pop     = rd_en & ~empty_w;
      // A pop in the same cycle frees the slot, so a full FIFO can still accept.
      push_ok = push & (~full_w | pop);
      ovf_evt = push & full_w & ~pop;

      if (pop) begin
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
        rd_ptr_d   = rd_ptr_q + AW'(1);
      end
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end

      unique case ({push_ok, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    if (ovf_evt) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_FIRST;
      nib_q      <= '0;
      wr_prev_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      nib_q      <= nib_d;
      wr_prev_q  <= wr;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push_ok) begin
      mem_q[wr_ptr_q] <= byte_w;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign empty    = empty_w;
  assign full     = full_w;
  assign count    = count_q;
  assign half     = (state_q == S_SECOND);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_fsk_rx_buffer.sv
// Directed and randomized bench for fsk_rx_buffer; two instances (HIGH_FIRST=1/0)
// share stimulus and are compared against a queue-based reference model.
module tb_fsk_rx_buffer;

  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, wr, flush, clr_ovf, rd_en;
  logic [3:0] data_in;

  logic [7:0]    rd_data_a, rd_data_b;
  logic          rd_valid_a, rd_valid_b, empty_a, empty_b, full_a, full_b;
  logic [CW-1:0] count_a, count_b;
  logic          half_a, half_b, overflow_a, overflow_b;

  fsk_rx_buffer #(.DEPTH(DEPTH), .HIGH_FIRST(1'b1)) u_hf1 (
    .clk(clk), .rst_n(rst_n), .wr(wr), .data_in(data_in), .flush(flush),
    .clr_ovf(clr_ovf), .rd_en(rd_en), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .empty(empty_a), .full(full_a), .count(count_a), .half(half_a),
    .overflow(overflow_a)
  );

  fsk_rx_buffer #(.DEPTH(DEPTH), .HIGH_FIRST(1'b0)) u_hf0 (
    .clk(clk), .rst_n(rst_n), .wr(wr), .data_in(data_in), .flush(flush),
    .clr_ovf(clr_ovf), .rd_en(rd_en), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .empty(empty_b), .full(full_b), .count(count_b), .half(half_b),
    .overflow(overflow_b)
  );

  int checks = 0;
  int errors = 0;

  // Model: queued entries are {first nibble, second nibble}; HIGH_FIRST=0 swaps them.
  logic [7:0] m_q[$];
  logic       m_prev, m_half, m_ovf, m_rv;
  logic [3:0] m_nib;
  logic [7:0] m_rdata;

  function automatic logic [7:0] swap(input logic [7:0] v);
    return {v[3:0], v[7:4]};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    logic cap, pop, push, was_full;
    logic [7:0] pair;
    if (!rst_n) begin
      m_q.delete();
      m_prev = 1'b0; m_half = 1'b0; m_ovf = 1'b0; m_rv = 1'b0;
      m_nib = 4'h0; m_rdata = 8'h00;
      return;
    end
    cap      = wr && !m_prev;
    m_prev   = wr;
    pop      = rd_en && (m_q.size() != 0);
    was_full = (m_q.size() == DEPTH);
    push     = 1'b0;
    pair     = 8'h00;
    m_rv     = 1'b0;
    if (flush) begin
      m_q.delete();
      m_half = 1'b0;
      if (clr_ovf) m_ovf = 1'b0;
      return;
    end
    if (cap) begin
      if (!m_half) begin
        m_half = 1'b1;
        m_nib  = data_in;
      end else begin
        m_half = 1'b0;
        push   = 1'b1;
        pair   = {m_nib, data_in};
      end
    end
    if (pop) begin
      m_rdata = m_q.pop_front();
      m_rv    = 1'b1;
    end
    if (push && was_full && !pop) m_ovf = 1'b1;
    else begin
      if (push) m_q.push_back(pair);
      if (clr_ovf) m_ovf = 1'b0;
    end
  endtask

  task automatic check_outputs();
    logic [7:0] cnt;
    cnt = 8'(m_q.size());
    chk("rd_valid_hf1", {7'b0, rd_valid_a}, {7'b0, m_rv});
    chk("rd_valid_hf0", {7'b0, rd_valid_b}, {7'b0, m_rv});
    chk("rd_data_hf1", rd_data_a, m_rdata);
    chk("rd_data_hf0", rd_data_b, swap(m_rdata));
    chk("count_hf1", 8'(count_a), cnt);
    chk("count_hf0", 8'(count_b), cnt);
    chk("empty_hf1", {7'b0, empty_a}, {7'b0, cnt == 8'd0});
    chk("empty_hf0", {7'b0, empty_b}, {7'b0, cnt == 8'd0});
    chk("full_hf1", {7'b0, full_a}, {7'b0, cnt == 8'(DEPTH)});
    chk("full_hf0", {7'b0, full_b}, {7'b0, cnt == 8'(DEPTH)});
    chk("half_hf1", {7'b0, half_a}, {7'b0, m_half});
    chk("half_hf0", {7'b0, half_b}, {7'b0, m_half});
    chk("overflow_hf1", {7'b0, overflow_a}, {7'b0, m_ovf});
    chk("overflow_hf0", {7'b0, overflow_b}, {7'b0, m_ovf});
  endtask

  task automatic step(input logic w, input logic [3:0] d, input logic fl,
                      input logic co, input logic re);
    wr = w; data_in = d; flush = fl; clr_ovf = co; rd_en = re;
    model_update();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, 4'($urandom), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic nib(input logic [3:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
    idle();
  endtask

  task automatic push_byte(input logic [7:0] b);
    nib(b[7:4]);
    nib(b[3:0]);
  endtask

  task automatic pop1();
    step(1'b0, 4'($urandom), 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; wr = 1'b0; data_in = 4'h0; flush = 1'b0; clr_ovf = 1'b0; rd_en = 1'b0;
    m_q.delete();
    m_prev = 1'b0; m_half = 1'b0; m_ovf = 1'b0; m_rv = 1'b0; m_nib = 4'h0; m_rdata = 8'h00;
    @(posedge clk);
    #1;
    do_reset();

    // 0x9,0x9 -> 0x99, single pop with one-cycle latency
    nib(4'h9); nib(4'h9);
    pop1(); idle();

    // held-high wr captures once; 0x3 then 0xA
    step(1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 4'($urandom), 1'b0, 1'b0, 1'b0);
    idle();
    nib(4'hA);
    pop1(); idle();

    // fill with 0x10..0x17, overflow on 0x18, drain in order
    for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
    push_byte(8'h18);
    for (int i = 0; i < 9; i++) pop1();
    idle();

    // clear overflow, refill, byte completes together with a pop
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) push_byte(8'h20 + 8'(i));
    nib(4'hC);
    step(1'b1, 4'hD, 1'b0, 1'b0, 1'b1);
    idle();
    for (int i = 0; i < 9; i++) pop1();

    // flush discards a half byte; 0x5,0x6 then pack to 0x56
    nib(4'hE);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    nib(4'h5); nib(4'h6);
    pop1(); idle();

    // overflow set wins over clr_ovf in the same cycle
    for (int i = 0; i < 8; i++) push_byte(8'(i * 17));
    nib(4'h7);
    step(1'b1, 4'h8, 1'b0, 1'b1, 1'b0);
    idle();
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);

    // pops while empty are ignored
    for (int i = 0; i < 3; i++) pop1();

    // reset mid-byte and mid-pop
    push_byte(8'h4B);
    nib(4'h1);
    rst_n = 1'b0;
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    nib(4'h2); nib(4'h3);
    pop1();
    rst_n = 1'b0;
    step(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
    idle();

    // randomized: producer-heavy phase then consumer-heavy phase
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 4'($urandom), ($urandom % 60) == 0, ($urandom % 16) == 0,
           ($urandom % 12) == 0);
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 4'($urandom), ($urandom % 60) == 0, ($urandom % 16) == 0,
           ($urandom % 2) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsk_rx_buffer.md
FSK_RX_BUFFER -- requirements
Module: fsk_rx_buffer

Interface
REQ-001 Parameter: DEPTH, default 8, number of byte entries in the FIFO (power of two, 2..16).
REQ-002 Parameter: HIGH_FIRST, default 1; 1 = first received nibble becomes byte bits [7:4], 0 = first nibble becomes bits [3:0].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 wr  input  1  nibble-valid strobe from the FSK demodulator; may stay high for more than one cycle.
REQ-006 data_in  input  4  demodulated nibble, valid while wr is high.
REQ-007 flush  input  1  synchronous clear of FIFO contents and any partial byte.
REQ-008 clr_ovf  input  1  clears the sticky overflow flag.
REQ-009 rd_en  input  1  consumer pop request.
REQ-010 rd_data  output  8  popped byte, registered.
REQ-011 rd_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-012 empty  output  1  FIFO holds zero bytes.
REQ-013 full  output  1  FIFO holds DEPTH bytes.
REQ-014 count  output  $clog2(DEPTH)+1  current byte occupancy, 0..DEPTH.
REQ-015 half  output  1  a first nibble is held awaiting its partner.
REQ-016 overflow  output  1  sticky: a completed byte was dropped.

Function
REQ-017 Capture: one nibble accepted per rising edge of wr, i.e. the cycle with wr=1 and the registered previous wr=0; data_in is sampled in that cycle; held-high wr captures nothing further.
REQ-018 Packing: first capture loads the nibble holding register and sets half=1; second capture forms the byte (order per HIGH_FIRST), clears half and issues a push in the same cycle.
REQ-019 Push: if not full, or if full with an accepted pop in the same cycle, the byte is written at wr_ptr and wr_ptr advances.
REQ-020 Push when full with no pop: byte discarded, pointers unchanged, overflow set to 1 the next cycle.
REQ-021 Pop: rd_en=1 and empty=0 -> head byte loaded into rd_data, rd_valid=1 on the following cycle, rd_ptr advances; latency one cycle from rd_en to rd_valid.
REQ-022 rd_en while empty is ignored: no pointer change, rd_valid=0, rd_data holds its last value.
REQ-023 Simultaneous push and pop: both accepted, count unchanged; when empty, pop is refused even if a push occurs that cycle (no write-through).
REQ-024 Pointers wrap modulo DEPTH; count = pushes minus pops, never exceeds DEPTH or underflows.
REQ-025 empty = (count==0), full = (count==DEPTH), both derived from registered count.
REQ-026 flush=1: count, pointers and half cleared, rd_valid forced 0, any push or pop that cycle suppressed; overflow and rd_data unchanged.
REQ-027 clr_ovf=1 clears overflow; if an overflow event occurs in the same cycle, overflow remains 1 (set wins).
REQ-028 flush has priority over capture, push and pop; rst_n has priority over everything.

Reset
REQ-029 rst_n=0 at a rising edge: rd_data=8'h00, rd_valid=0, empty=1, full=0, count=0, half=0, overflow=0, pointers=0, previous-wr register=0.
REQ-030 Reset asserted mid-byte or mid-pop discards the partial nibble and any pending rd_valid; the first wr rising edge after release is treated as a first nibble.
REQ-031 Memory contents need not be reset; no output may depend on unwritten entries.

Verification
REQ-032 Reset then wr pulses with data_in=4'b1001 twice, HIGH_FIRST=1 -> count=1, half=0; rd_en -> rd_valid one cycle later with rd_data=8'h99, empty=1.
REQ-033 Nibbles 4'h3 then 4'hA with HIGH_FIRST=0 -> popped byte 8'hA3; wr held high 5 cycles counts as one nibble only.
REQ-034 Push 8 bytes 8'h10..8'h17, then one more byte 8'h18 -> full=1, count=8, overflow=1; pop 8 -> 8'h10..8'h17 in order, empty=1.
REQ-035 Full FIFO, byte completes in the same cycle as rd_en -> count stays 8, overflow stays 0, last pop returns the new byte.
REQ-036 One nibble captured (half=1), then flush -> half=0, count=0; next two nibbles 4'h5,4'h6 produce 8'h56; clr_ovf and overflow event in same cycle -> overflow=1.
REQ-037 rd_en asserted while empty for 3 cycles -> rd_valid stays 0, rd_data unchanged, count stays 0.
